// File: rtl/hdmi_pattern_gen.sv
// HDMI-style timing and incrementing YCrCb pattern source, N pixels per clock.
// Optional HDMI_PATTERN_FRAME_RESET_EN: restart the pixel pattern at 0 on every frame.
module hdmi_pattern_gen #(
  parameter int N                 = 2,
  parameter int X_RES             = 2160,
  parameter int Y_RES             = 1200,
  parameter int H_SYNC_CYC        = 20,
  parameter int H_BACK_PORCH_CYC  = 46,
  parameter int H_FRONT_PORCH_CYC = 40,
  parameter int V_SYNC_CYC        = 2,
  parameter int V_BACK_PORCH_CYC  = 234,
  parameter int V_FRONT_PORCH_CYC = 28
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic               o_hdmi_v_sync,
  output logic               o_hdmi_h_sync,
  output logic               o_hdmi_data_valid,
  output logic [N-1:0][7:0]  o_hdmi_data_y,
  output logic [N-1:0][7:0]  o_hdmi_data_cr,
  output logic [N-1:0][7:0]  o_hdmi_data_cb,
  output logic               o_busy
);
  localparam int HS     = H_SYNC_CYC / N;
  localparam int HB     = H_BACK_PORCH_CYC / N;
  localparam int HA     = X_RES / N;
  localparam int HF     = H_FRONT_PORCH_CYC / N;
  localparam int L      = HS + HB + HA + HF;
  localparam int VLINES = V_SYNC_CYC + V_BACK_PORCH_CYC + Y_RES + V_FRONT_PORCH_CYC;
  localparam int HCW    = $clog2(L + 1);
  localparam int VCW    = $clog2(VLINES + 1);
  localparam int PW     = 8 * N;

  if ((H_SYNC_CYC % N) != 0 || (H_BACK_PORCH_CYC % N) != 0 ||
      (X_RES % N) != 0 || (H_FRONT_PORCH_CYC % N) != 0) begin : g_param_check
    $error("hdmi_pattern_gen: horizontal timing parameters must be divisible by N");
  end

  typedef enum logic [1:0] {H_SYNC, H_BACK, H_ACTIVE, H_FRONT} h_state_t;
  typedef enum logic [2:0] {V_IDLE, V_SYNC, V_BACK, V_ACTIVE, V_FRONT} v_state_t;

  h_state_t          h_state_q, h_state_d;
  v_state_t          v_state_q, v_state_d;
  logic [HCW-1:0]    hcnt_q, hcnt_d, h_len;
  logic [VCW-1:0]    vcnt_q, vcnt_d, v_len;
  logic [PW-1:0]     p_q, p_d, data_q, data_d;
  logic              v_sync_q, v_sync_d, h_sync_q, h_sync_d;
  logic              valid_q, valid_d, busy_q, busy_d;
  logic              h_last, v_last;

  always_comb begin
    h_len = HCW'(HS);
    case (h_state_q)
      H_SYNC:   h_len = HCW'(HS);
      H_BACK:   h_len = HCW'(HB);
      H_ACTIVE: h_len = HCW'(HA);
      H_FRONT:  h_len = HCW'(HF);
      default:  h_len = HCW'(HS);
    endcase
    v_len = VCW'(V_SYNC_CYC);
    case (v_state_q)
      V_SYNC:   v_len = VCW'(V_SYNC_CYC);
      V_BACK:   v_len = VCW'(V_BACK_PORCH_CYC);
      V_ACTIVE: v_len = VCW'(Y_RES);
      V_FRONT:  v_len = VCW'(V_FRONT_PORCH_CYC);
      default:  v_len = VCW'(V_SYNC_CYC);
    endcase
  end

  assign h_last = (hcnt_q == h_len - HCW'(1));
  assign v_last = (vcnt_q == v_len - VCW'(1));

  always_comb begin
    h_state_d = h_state_q;
    v_state_d = v_state_q;
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    p_d       = p_q;
    data_d    = data_q;
    // Outputs are a registered image of the current timing state.
    v_sync_d  = (v_state_q == V_SYNC);
    h_sync_d  = (v_state_q != V_IDLE) && (h_state_q == H_SYNC);
    valid_d   = (v_state_q == V_ACTIVE) && (h_state_q == H_ACTIVE);
    busy_d    = (v_state_q != V_IDLE);

    if (valid_d) begin
      data_d = p_q;
      p_d    = p_q + PW'(1);
    end
`ifdef HDMI_PATTERN_FRAME_RESET_EN
    if (v_state_q == V_SYNC && vcnt_q == '0 && h_state_q == H_SYNC && hcnt_q == '0) begin
      p_d = '0;
    end
`endif

    if (v_state_q == V_IDLE) begin
      h_state_d = H_SYNC;
      hcnt_d    = '0;
      vcnt_d    = '0;
      if (en) v_state_d = V_SYNC;
    end else if (!h_last) begin
      hcnt_d = hcnt_q + HCW'(1);
    end else begin
      hcnt_d = '0;
      case (h_state_q)
        H_SYNC:   h_state_d = H_BACK;
        H_BACK:   h_state_d = H_ACTIVE;
        H_ACTIVE: h_state_d = H_FRONT;
        default: begin
          // End of line: advance the vertical side only here.
          h_state_d = H_SYNC;
          if (!v_last) begin
            vcnt_d = vcnt_q + VCW'(1);
          end else begin
            vcnt_d = '0;
            case (v_state_q)
              V_SYNC:   v_state_d = V_BACK;
              V_BACK:   v_state_d = V_ACTIVE;
              V_ACTIVE: v_state_d = V_FRONT;
              V_FRONT:  v_state_d = en ? V_SYNC : V_IDLE;
              default:  v_state_d = V_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_state_q <= H_SYNC;
      v_state_q <= V_IDLE;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      p_q       <= '0;
      data_q    <= '0;
      v_sync_q  <= 1'b0;
      h_sync_q  <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      h_state_q <= h_state_d;
      v_state_q <= v_state_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      p_q       <= p_d;
      data_q    <= data_d;
      v_sync_q  <= v_sync_d;
      h_sync_q  <= h_sync_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign o_hdmi_v_sync     = v_sync_q;
  assign o_hdmi_h_sync     = h_sync_q;
  assign o_hdmi_data_valid = valid_q;
  assign o_busy            = busy_q;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign o_hdmi_data_y[gi]  = data_q[8*gi +: 8];
    assign o_hdmi_data_cr[gi] = data_q[8*gi +: 8];
    assign o_hdmi_data_cb[gi] = data_q[8*gi +: 8];
  end

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Bench for hdmi_pattern_gen: small timing parameters, frame-position reference model.
module tb_hdmi_pattern_gen;
  localparam int N = 2, X_RES = 8, Y_RES = 4;
  localparam int HSP = 2, HBP = 2, HFP = 2;
  localparam int VS = 1, VB = 1, VF = 1;
  localparam int HS = HSP / N, HB = HBP / N, HA = X_RES / N, HF = HFP / N;
  localparam int L = HS + HB + HA + HF;
  localparam int FL = VS + VB + Y_RES + VF;
  localparam int F = L * FL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic vs_o, hs_o, dv_o, busy_o;
  logic [N-1:0][7:0] y_o, cr_o, cb_o;

  always #5 clk = ~clk;

  hdmi_pattern_gen #(
    .N(N), .X_RES(X_RES), .Y_RES(Y_RES),
    .H_SYNC_CYC(HSP), .H_BACK_PORCH_CYC(HBP), .H_FRONT_PORCH_CYC(HFP),
    .V_SYNC_CYC(VS), .V_BACK_PORCH_CYC(VB), .V_FRONT_PORCH_CYC(VF)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .o_hdmi_v_sync(vs_o), .o_hdmi_h_sync(hs_o), .o_hdmi_data_valid(dv_o),
    .o_hdmi_data_y(y_o), .o_hdmi_data_cr(cr_o), .o_hdmi_data_cb(cb_o),
    .o_busy(busy_o)
  );

  int total = 0;
  int bad = 0;

  // Reference: a running frame is a cycle position; outputs follow position by one clock.
  bit          ms_run;
  int          ms_pos, m_line, m_col;
  logic [15:0] m_p;
  logic        e_vs, e_hs, e_dv, e_busy;
  logic [15:0] e_data;

  always @(posedge clk) begin
    if (rst) begin
      ms_run = 0; ms_pos = 0; m_p = '0;
      e_vs = 0; e_hs = 0; e_dv = 0; e_busy = 0; e_data = '0;
    end else begin
      if (ms_run) begin
        m_line = ms_pos / L;
        m_col  = ms_pos % L;
`ifdef HDMI_PATTERN_FRAME_RESET_EN
        if (ms_pos == 0) m_p = '0;
`endif
        e_vs   = (m_line < VS);
        e_hs   = (m_col < HS);
        e_dv   = (m_line >= VS + VB) && (m_line < VS + VB + Y_RES) &&
                 (m_col >= HS + HB) && (m_col < HS + HB + HA);
        e_busy = 1'b1;
        if (e_dv) begin
          e_data = m_p;
          m_p    = m_p + 16'd1;
        end
      end else begin
        e_vs = 0; e_hs = 0; e_dv = 0; e_busy = 0;
      end
      if (!ms_run) begin
        if (en) begin ms_run = 1; ms_pos = 0; end
      end else if (ms_pos == F - 1) begin
        if (en) ms_pos = 0;
        else ms_run = 0;
      end else begin
        ms_pos++;
      end
    end
  end

  wire [51:0] obs_vec = {vs_o, hs_o, dv_o, busy_o, y_o, cr_o, cb_o};
  wire [51:0] exp_vec = {e_vs, e_hs, e_dv, e_busy, e_data, e_data, e_data};

  task automatic test_reset();
    rst = 1'b1; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (obs_vec !== 52'd0) begin
        bad++; $display("FAIL reset_state cyc=%0d got=%h exp=0", i, obs_vec);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_start_and_timing();
    int c, first_dv, runs, run_len, min_run, max_run;
    logic [15:0] first_data;
    en = 1'b1;
    c = 0;
    do begin
      @(posedge clk); #1; c++;
    end while (!vs_o && c < 10);
    total++;
    if (c != 2 || !vs_o) begin
      bad++; $display("FAIL start_latency got=%0d exp=2 vs=%b", c, vs_o);
    end
    first_dv = -1; runs = 0; run_len = 0; min_run = 999; max_run = 0; first_data = '0;
    for (int i = 0; i < F; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      total++;
      if (vs_o !== (i < L) || hs_o !== ((i % L) == 0)) begin
        bad++; $display("FAIL sync_shape i=%0d got vs=%b hs=%b exp vs=%b hs=%b",
                        i, vs_o, hs_o, (i < L), ((i % L) == 0));
      end
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("FAIL start_model i=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (dv_o) begin
        if (first_dv < 0) begin first_dv = i; first_data = y_o; end
        run_len++;
      end else if (run_len > 0) begin
        runs++;
        if (run_len < min_run) min_run = run_len;
        if (run_len > max_run) max_run = run_len;
        run_len = 0;
      end
    end
    total++;
    if (first_dv != 16) begin
      bad++; $display("FAIL first_beat_cycle got=%0d exp=16", first_dv);
    end
    total++;
    if (runs != Y_RES || min_run != HA || max_run != HA) begin
      bad++; $display("FAIL run_shape got runs=%0d min=%0d max=%0d exp runs=%0d len=%0d",
                      runs, min_run, max_run, Y_RES, HA);
    end
    total++;
    if (first_data !== 16'h0000) begin
      bad++; $display("FAIL first_pixel got=%h exp=0000", first_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] f2, f3, exp_f2, exp_f3;
    bit got2, got3;
    got2 = 0; got3 = 0; f2 = '0; f3 = '0;
`ifdef HDMI_PATTERN_FRAME_RESET_EN
    exp_f2 = 16'd0; exp_f3 = 16'd0;
`else
    exp_f2 = 16'd16; exp_f3 = 16'd32;
`endif
    for (int j = 0; j < 2 * F; j++) begin
      @(posedge clk); #1;
      if (j == 0 || j == F) begin
        total++;
        if (vs_o !== 1'b1) begin
          bad++; $display("FAIL frame_restart j=%0d got vs=%b exp=1", j, vs_o);
        end
      end
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("FAIL b2b_model j=%0d got=%h exp=%h", j, obs_vec, exp_vec);
      end
      if (dv_o && j < F && !got2) begin got2 = 1; f2 = y_o; end
      if (dv_o && j >= F && !got3) begin got3 = 1; f3 = y_o; end
    end
    total++;
    if (f2 !== exp_f2 || f3 !== exp_f3) begin
      bad++; $display("FAIL frame_first_pixel got f2=%0d f3=%0d exp f2=%0d f3=%0d",
                      f2, f3, exp_f2, exp_f3);
    end
  endtask

  task automatic test_stop();
    int c;
    c = 0;
    @(posedge clk); #1;
    total++;
    if (vs_o !== 1'b1) begin
      bad++; $display("FAIL stop_frame_start got vs=%b exp=1", vs_o);
    end
    while (busy_o && c < 200) begin
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("FAIL stop_model c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      end
      if (c == 20) en = 1'b0;
      @(posedge clk); #1; c++;
    end
    total++;
    if (c != F) begin
      bad++; $display("FAIL busy_fall got=%0d exp=%0d", c, F);
    end
    for (int i = 0; i < 30; i++) begin
      total++;
      if ({vs_o, hs_o, dv_o, busy_o} !== 4'b0000) begin
        bad++; $display("FAIL idle_quiet i=%0d got=%b exp=0000", i, {vs_o, hs_o, dv_o, busy_o});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    int c;
    en = 1'b1;
    c = 0;
    while (!dv_o && c < 200) begin @(posedge clk); #1; c++; end
    total++;
    if (!dv_o) begin
      bad++; $display("FAIL wait_active got dv=%b exp=1", dv_o);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (obs_vec !== 52'd0) begin
      bad++; $display("FAIL midframe_reset got=%h exp=0", obs_vec);
    end
    rst = 1'b0;
    c = 0;
    do begin @(posedge clk); #1; c++; end while (!vs_o && c < 10);
    total++;
    if (c != 2 || !vs_o) begin
      bad++; $display("FAIL restart_latency got=%0d exp=2", c);
    end
    c = 0;
    while (!dv_o && c < 100) begin @(posedge clk); #1; c++; end
    total++;
    if (c != 16 || y_o !== 16'h0000) begin
      bad++; $display("FAIL restart_first_beat got c=%0d data=%h exp c=16 data=0000", c, y_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("FAIL random_model i=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if ($urandom_range(0, 99) < 4) en = ~en;
      rst = ($urandom_range(0, 599) == 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_and_timing();
    test_back_to_back();
    test_stop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
